writeback_arbiter: RTL and testbench

Write-back stage that feeds the register file's single write port (RegWrite, addrW_reg, write_reg) from two result sources: the single-cycle ALU path and the load/memory path. It arbitrates between the sources and buffers ALU results in a small FIFO when the port is taken. It drops writes to r0 and registers the chosen write so the register file sees clean, glitch-free write controls. It also tells hazard logic whether a register still has a write pending.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_fifo.sv | 91 +++++++++
 rtl/writeback_arbiter.sv | 140 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared write-back definitions: default widths, the hard-wired zero register,
// and the arbitration source encoding.
package wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_DRAIN,
    SRC_MEM,
    SRC_FIFO,
    SRC_ALU
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for buffered ALU results; exposes every slot's address
// and occupancy so hazard logic can search pending writes.
module wb_fifo import wb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [ADDR_W-1:0]              push_addr,
  input  logic [DATA_W-1:0]              push_data,
  input  logic                           pop,
  output logic [ADDR_W-1:0]              head_addr,
  output logic [DATA_W-1:0]              head_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH):0]         count,
  output logic [DEPTH-1:0]               ent_vld,
  output logic [DEPTH-1:0][ADDR_W-1:0]   ent_addr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Slot i is live when its distance from the head is below the fill count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i]  = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
      ent_addr[i] = addr_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: mem beats buffered ALU results, with a
// starvation guard that forces the ALU buffer to drain; write controls are registered.
module writeback_arbiter import wb_pkg::*; #(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] addrW_reg,
  output logic [DATA_W-1:0] write_reg,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_hit,
  output logic              busy
);

  localparam int SV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SV_W-1:0] STARVE_MAX = SV_W'(STARVE_LIMIT);

  logic                             fifo_push, fifo_pop;
  logic                             fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]      fifo_count;
  logic [ADDR_W-1:0]                head_addr;
  logic [DATA_W-1:0]                head_data;
  logic [FIFO_DEPTH-1:0]            ent_vld;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent_addr;

  wb_src_e           sel;
  logic              drain;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [SV_W-1:0]   starve_q, starve_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] addr_w_q, addr_w_d;
  logic [DATA_W-1:0] write_q, write_d;
  logic              hit;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_addr (alu_addr),
    .push_data (alu_data),
    .pop       (fifo_pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .ent_vld   (ent_vld),
    .ent_addr  (ent_addr)
  );

  always_comb begin
    sel      = SRC_NONE;
    win_addr = '0;
    win_data = '0;
    drain    = (starve_q == STARVE_MAX) & ~fifo_empty;
    if (drain) begin
      sel      = SRC_DRAIN;
      win_addr = head_addr;
      win_data = head_data;
    end else if (mem_valid) begin
      sel      = SRC_MEM;
      win_addr = mem_addr;
      win_data = mem_data;
    end else if (!fifo_empty) begin
      sel      = SRC_FIFO;
      win_addr = head_addr;
      win_data = head_data;
    end else if (alu_valid) begin
      sel      = SRC_ALU;
      win_addr = alu_addr;
      win_data = alu_data;
    end

    mem_ready = ~rst & ~drain;
    alu_ready = ~rst & ~fifo_full;
    fifo_pop  = (sel == SRC_DRAIN) || (sel == SRC_FIFO);
    fifo_push = alu_valid & alu_ready & (sel != SRC_ALU);

    // r0 still consumes the slot; only the enable is suppressed.
    reg_write_d = (sel != SRC_NONE) && (32'(win_addr) != REG_ZERO);
    addr_w_d    = addr_w_q;
    write_d     = write_q;
    if (sel != SRC_NONE) begin
      addr_w_d = win_addr;
      write_d  = win_data;
    end

    starve_d = starve_q;
    if (fifo_pop || !fifo_full) begin
      starve_d = '0;
    end else if (sel == SRC_MEM && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    hit = reg_write_q && (addr_w_q == chk_addr);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_vld[i] && ent_addr[i] == chk_addr) hit = 1'b1;
    end
    chk_hit = hit && (32'(chk_addr) != REG_ZERO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q    <= '0;
      reg_write_q <= 1'b0;
      addr_w_q    <= '0;
      write_q     <= '0;
    end else begin
      starve_q    <= starve_d;
      reg_write_q <= reg_write_d;
      addr_w_q    <= addr_w_d;
      write_q     <= write_d;
    end
  end

  assign RegWrite  = reg_write_q;
  assign addrW_reg = addr_w_q;
  assign write_reg = write_q;
  assign busy      = (fifo_count != '0) | reg_write_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a queue-based reference model checked
// every cycle, plus literal expectations pinned on selected cycles.
module tb_writeback_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr, mem_addr, chk_addr;
  logic [31:0] alu_data, mem_data;
  logic        RegWrite, chk_hit, busy;
  logic [4:0]  addrW_reg;
  logic [31:0] write_reg;

  writeback_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .RegWrite  (RegWrite),
    .addrW_reg (addrW_reg),
    .write_reg (write_reg),
    .chk_addr  (chk_addr),
    .chk_hit   (chk_hit),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit av; logic [4:0] aa; logic [31:0] ad;
    bit mv; logic [4:0] ma; logic [31:0] md; logic [4:0] ca;
    bit pin; bit p_we; logic [4:0] p_a; logic [31:0] p_d;
    bit p_hit; bit p_ar; bit p_mr; bit p_busy;
  } vec_t;

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;

  vec_t vec[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(bit r, bit av, logic [4:0] aa, logic [31:0] ad,
                              bit mv, logic [4:0] ma, logic [31:0] md, logic [4:0] ca);
    vec_t v;
    v = '{default: '0};
    v.rst = r; v.av = av; v.aa = aa; v.ad = ad;
    v.mv = mv; v.ma = ma; v.md = md; v.ca = ca;
    vec.push_back(v);
  endfunction

  function automatic void pin(bit we, logic [4:0] a, logic [31:0] d,
                              bit hit, bit ar, bit mr, bit bsy);
    int n;
    n = vec.size() - 1;
    vec[n].pin = 1'b1; vec[n].p_we = we; vec[n].p_a = a; vec[n].p_d = d;
    vec[n].p_hit = hit; vec[n].p_ar = ar; vec[n].p_mr = mr; vec[n].p_busy = bsy;
  endfunction

  // Reference model state
  ent_t        fq[$];
  int          starve;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  initial begin
    bit   full, drain, e_hit, alu_acc;
    int   src;
    ent_t w;

    rst = 1'b1;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0; chk_addr = 0;
    fq.delete(); starve = 0; m_we = 0; m_addr = 0; m_data = 0;

    // reset / lone ALU result
    add(1,0,0,0, 0,0,0, 0);                 pin(0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0, 0);
    add(0,0,0,0, 0,0,0, 0);                 pin(0,0,0, 0,1,1,0);
    add(0,1,3,32'hDEADBEEF, 0,0,0, 3);      pin(0,0,0, 0,1,1,0);
    add(0,0,0,0, 0,0,0, 3);                 pin(1,3,32'hDEADBEEF, 1,1,1,1);
    add(0,0,0,0, 0,0,0, 3);                 pin(0,0,0, 0,1,1,0);
    // mem and ALU together
    add(0,1,6,32'h22, 1,5,32'h11, 6);       pin(0,0,0, 0,1,1,0);
    add(0,0,0,0, 0,0,0, 6);                 pin(1,5,32'h11, 1,1,1,1);
    add(0,0,0,0, 0,0,0, 6);                 pin(1,6,32'h22, 1,1,1,1);
    add(0,0,0,0, 0,0,0, 6);                 pin(0,0,0, 0,1,1,0);
    // writes to r0
    add(0,1,0,32'hFFFFFFFF, 0,0,0, 0);      pin(0,0,0, 0,1,1,0);
    add(0,0,0,0, 1,0,32'hFFFFFFFF, 0);      pin(0,0,0, 0,1,1,0);
    add(0,0,0,0, 0,0,0, 0);                 pin(0,0,0, 0,1,1,0);
    add(0,1,0,32'hFFFFFFFF, 1,7,32'h77, 0);
    add(0,0,0,0, 0,0,0, 0);                 pin(1,7,32'h77, 0,1,1,1);
    add(0,0,0,0, 0,0,0, 0);                 pin(0,0,0, 0,1,1,0);
    // fill FIFO then starve it with mem
    add(0,1,9,32'h90, 1,8,32'h80, 9);
    add(0,1,11,32'hB0, 1,10,32'hA0, 9);     pin(1,8,32'h80, 1,1,1,1);
    add(0,1,13,32'hD0, 1,12,32'hC0, 11);    pin(1,10,32'hA0, 1,0,1,1);
    add(0,1,13,32'hD0, 1,14,32'hE0, 11);
    add(0,1,13,32'hD0, 1,15,32'hF0, 11);
    add(0,1,13,32'hD0, 1,16,32'h100, 11);   pin(1,15,32'hF0, 1,0,1,1);
    add(0,1,13,32'hD0, 1,17,32'h110, 11);   pin(1,16,32'h100, 1,0,0,1);
    add(0,1,13,32'hD0, 1,17,32'h110, 11);   pin(1,9,32'h90, 1,1,1,1);
    add(0,0,0,0, 0,0,0, 13);                pin(1,17,32'h110, 1,0,1,1);
    add(0,0,0,0, 0,0,0, 13);                pin(1,11,32'hB0, 1,1,1,1);
    add(0,0,0,0, 0,0,0, 13);                pin(1,13,32'hD0, 1,1,1,1);
    add(0,0,0,0, 0,0,0, 13);                pin(0,0,0, 0,1,1,0);
    // reset mid-operation
    add(0,1,21,32'h210, 1,20,32'h200, 21);
    add(0,1,23,32'h230, 1,22,32'h220, 21);  pin(1,20,32'h200, 1,1,1,1);
    add(0,0,0,0, 1,24,32'h240, 21);         pin(1,22,32'h220, 1,0,1,1);
    add(1,0,0,0, 0,0,0, 21);                pin(0,0,0, 0,0,0,0);
    add(0,0,0,0, 0,0,0, 21);                pin(0,0,0, 0,1,1,0);
    add(0,0,0,0, 0,0,0, 21);                pin(0,0,0, 0,1,1,0);
    add(0,1,25,32'h250, 0,0,0, 25);
    add(0,0,0,0, 0,0,0, 25);                pin(1,25,32'h250, 1,1,1,1);
    add(0,0,0,0, 0,0,0, 25);                pin(0,0,0, 0,1,1,0);

    for (int i = 0; i < vec.size(); i++) begin
      @(posedge clk);
      #1;
      rst       = vec[i].rst;
      alu_valid = vec[i].av; alu_addr = vec[i].aa; alu_data = vec[i].ad;
      mem_valid = vec[i].mv; mem_addr = vec[i].ma; mem_data = vec[i].md;
      chk_addr  = vec[i].ca;
      @(negedge clk);

      if (vec[i].pin) begin
        chk($sformatf("pin%0d RegWrite", i), 32'(RegWrite), 32'(vec[i].p_we));
        chk($sformatf("pin%0d chk_hit", i), 32'(chk_hit), 32'(vec[i].p_hit));
        chk($sformatf("pin%0d alu_ready", i), 32'(alu_ready), 32'(vec[i].p_ar));
        chk($sformatf("pin%0d mem_ready", i), 32'(mem_ready), 32'(vec[i].p_mr));
        chk($sformatf("pin%0d busy", i), 32'(busy), 32'(vec[i].p_busy));
        if (vec[i].p_we || vec[i].rst) begin
          chk($sformatf("pin%0d addrW_reg", i), 32'(addrW_reg), 32'(vec[i].p_a));
          chk($sformatf("pin%0d write_reg", i), write_reg, vec[i].p_d);
        end
      end

      if (rst) begin
        fq.delete(); starve = 0; m_we = 0; m_addr = 0; m_data = 0;
        chk($sformatf("c%0d rst RegWrite", i), 32'(RegWrite), 32'(0));
        chk($sformatf("c%0d rst addrW_reg", i), 32'(addrW_reg), 32'(0));
        chk($sformatf("c%0d rst write_reg", i), write_reg, 32'(0));
        chk($sformatf("c%0d rst ready", i), {30'b0, alu_ready, mem_ready}, 32'(0));
        chk($sformatf("c%0d rst busy", i), 32'(busy), 32'(0));
      end else begin
        full  = (fq.size() == DEPTH);
        drain = (starve == LIMIT);
        e_hit = 0;
        if (chk_addr != 0) begin
          for (int k = 0; k < fq.size(); k++) if (fq[k].a == chk_addr) e_hit = 1;
          if (m_we && m_addr == chk_addr) e_hit = 1;
        end
        chk($sformatf("c%0d RegWrite", i), 32'(RegWrite), 32'(m_we));
        if (m_we) begin
          chk($sformatf("c%0d addrW_reg", i), 32'(addrW_reg), 32'(m_addr));
          chk($sformatf("c%0d write_reg", i), write_reg, m_data);
        end
        chk($sformatf("c%0d alu_ready", i), 32'(alu_ready), 32'(!full));
        chk($sformatf("c%0d mem_ready", i), 32'(mem_ready), 32'(!drain));
        chk($sformatf("c%0d busy", i), 32'(busy), 32'(fq.size() != 0 || m_we));
        chk($sformatf("c%0d chk_hit", i), 32'(chk_hit), 32'(e_hit));

        // 0 none, 1 buffered head, 2 mem, 3 ALU pass-through
        src = 0;
        w   = '{a: 0, d: 0};
        if (drain)                begin src = 1; w = fq[0]; end
        else if (mem_valid)       begin src = 2; w = '{a: mem_addr, d: mem_data}; end
        else if (fq.size() != 0)  begin src = 1; w = fq[0]; end
        else if (alu_valid)       begin src = 3; w = '{a: alu_addr, d: alu_data}; end
        alu_acc = alu_valid && !full;
        if (src == 1) void'(fq.pop_front());
        if (alu_acc && src != 3) fq.push_back('{a: alu_addr, d: alu_data});
        if (src == 1 || !full) starve = 0;
        else if (src == 2 && starve < LIMIT) starve++;
        m_we = (src != 0) && (w.a != 0);
        if (src != 0) begin m_addr = w.a; m_data = w.d; end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
